// File: rtl/sinal_pkg.sv
// Shared types, mode encodings and a width helper for the signal-light sequencer.
// Build option: SINAL_AMBER_EN enables the amber phase.
package sinal_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        GREEN = 2'd1,
        AMBER = 2'd2,
        FLASH = 2'd3
    } estado_t;

    localparam logic [1:0] MODO_CICLO = 2'b00;
    localparam logic [1:0] MODO_VERDE = 2'b01;
    localparam logic [1:0] MODO_PISCA = 2'b10;
    localparam logic [1:0] MODO_OFF   = 2'b11;

    // Longest phase length, used to size the per-channel tick counter.
    function automatic int unsigned max_ticks(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sinal_canal.sv
// One signal-light channel: OFF/GREEN/[AMBER]/FLASH sequencer driven by the shared tick.
// Build option: SINAL_AMBER_EN adds the amber phase and the amarelo output.
module sinal_canal
    import sinal_pkg::*;
#(
    parameter int unsigned GREEN_TICKS = 8,
    parameter int unsigned FLASH_HALF  = 1,
    parameter int unsigned FLASH_TICKS = 6,
`ifdef SINAL_AMBER_EN
    parameter int unsigned AMBER_TICKS = 2,
`endif
    parameter int unsigned PC_W        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       en,
    input  logic [1:0] modo,
    output logic       verde,
    output logic       vermelho,
`ifdef SINAL_AMBER_EN
    output logic       amarelo,
`endif
    output logic       ciclo_fim
);

    localparam int unsigned HC_W = $clog2(FLASH_HALF + 1);

    estado_t         estado_q;
    logic [PC_W-1:0] pc_q;
    logic [HC_W-1:0] hc_q;
    logic            verde_fixo_q;
    logic            verde_q;
    logic            vermelho_q;
    logic            ciclo_fim_q;
`ifdef SINAL_AMBER_EN
    logic            amarelo_q;
`endif

    logic [PC_W-1:0] pc_inc;
    logic            desliga;
    logic            meio_fim;

    assign pc_inc   = pc_q + PC_W'(1);
    assign desliga  = !en || (modo == MODO_OFF);
    assign meio_fim = (hc_q == HC_W'(FLASH_HALF - 1));

    // Phase sequencer; a steady-green channel re-reads the mode on every tick,
    // every other phase only at its own end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q     <= OFF;
            pc_q         <= '0;
            hc_q         <= '0;
            verde_fixo_q <= 1'b0;
            verde_q      <= 1'b0;
            vermelho_q   <= 1'b0;
            ciclo_fim_q  <= 1'b0;
`ifdef SINAL_AMBER_EN
            amarelo_q    <= 1'b0;
`endif
        end else begin
            ciclo_fim_q <= 1'b0;
            if (desliga) begin
                estado_q     <= OFF;
                pc_q         <= '0;
                hc_q         <= '0;
                verde_fixo_q <= 1'b0;
                verde_q      <= 1'b0;
                vermelho_q   <= 1'b0;
`ifdef SINAL_AMBER_EN
                amarelo_q    <= 1'b0;
`endif
            end else begin
                case (estado_q)
                    OFF: begin
                        pc_q <= '0;
                        hc_q <= '0;
                        if (modo == MODO_PISCA) begin
                            estado_q   <= FLASH;
                            vermelho_q <= 1'b1;
                        end else begin
                            estado_q     <= GREEN;
                            verde_q      <= 1'b1;
                            verde_fixo_q <= (modo == MODO_VERDE);
                        end
                    end
                    GREEN: begin
                        if (tick) begin
                            if (verde_fixo_q) begin
                                if (modo == MODO_PISCA) begin
                                    estado_q     <= FLASH;
                                    verde_q      <= 1'b0;
                                    vermelho_q   <= 1'b1;
                                    hc_q         <= '0;
                                    pc_q         <= '0;
                                    verde_fixo_q <= 1'b0;
                                end else if (modo == MODO_CICLO) begin
                                    verde_fixo_q <= 1'b0;
                                end
                            end else if (pc_inc == PC_W'(GREEN_TICKS)) begin
                                pc_q <= '0;
                                if (modo == MODO_VERDE) begin
                                    verde_fixo_q <= 1'b1;
`ifdef SINAL_AMBER_EN
                                end else if (modo == MODO_CICLO) begin
                                    estado_q  <= AMBER;
                                    verde_q   <= 1'b0;
                                    amarelo_q <= 1'b1;
`endif
                                end else begin
                                    estado_q   <= FLASH;
                                    verde_q    <= 1'b0;
                                    vermelho_q <= 1'b1;
                                    hc_q       <= '0;
                                end
                            end else begin
                                pc_q <= pc_inc;
                            end
                        end
                    end
`ifdef SINAL_AMBER_EN
                    AMBER: begin
                        if (tick) begin
                            if (pc_inc == PC_W'(AMBER_TICKS)) begin
                                estado_q   <= FLASH;
                                amarelo_q  <= 1'b0;
                                vermelho_q <= 1'b1;
                                pc_q       <= '0;
                                hc_q       <= '0;
                            end else begin
                                pc_q <= pc_inc;
                            end
                        end
                    end
`endif
                    FLASH: begin
                        if (tick) begin
                            if (pc_inc == PC_W'(FLASH_TICKS)) begin
                                pc_q <= '0;
                                hc_q <= '0;
                                if (modo == MODO_PISCA) begin
                                    vermelho_q <= 1'b1;
                                end else begin
                                    estado_q     <= GREEN;
                                    vermelho_q   <= 1'b0;
                                    verde_q      <= 1'b1;
                                    ciclo_fim_q  <= 1'b1;
                                    verde_fixo_q <= (modo == MODO_VERDE);
                                end
                            end else begin
                                pc_q <= pc_inc;
                                if (meio_fim) begin
                                    hc_q       <= '0;
                                    vermelho_q <= ~vermelho_q;
                                end else begin
                                    hc_q <= hc_q + HC_W'(1);
                                end
                            end
                        end
                    end
                    default: begin
                        estado_q   <= OFF;
                        verde_q    <= 1'b0;
                        vermelho_q <= 1'b0;
                        pc_q       <= '0;
                        hc_q       <= '0;
                    end
                endcase
            end
        end
    end

    assign verde     = verde_q;
    assign vermelho  = vermelho_q;
    assign ciclo_fim = ciclo_fim_q;
`ifdef SINAL_AMBER_EN
    assign amarelo   = amarelo_q;
`endif

endmodule

// File: rtl/sinal_intermitente_multi.sv
// N-channel green/flashing-red light sequencer sharing one tick prescaler.
// Build option: SINAL_AMBER_EN adds an amber phase and the amarelo port.
module sinal_intermitente_multi
    import sinal_pkg::*;
#(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned TICK_DIV    = 25000000,
    parameter int unsigned GREEN_TICKS = 8,
    parameter int unsigned FLASH_HALF  = 1,
    parameter int unsigned FLASH_TICKS = 6,
    parameter int unsigned AMBER_TICKS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   en,
    input  logic [2*N_CH-1:0] modo,
    output logic [N_CH-1:0]   verde,
    output logic [N_CH-1:0]   vermelho,
`ifdef SINAL_AMBER_EN
    output logic [N_CH-1:0]   amarelo,
`endif
    output logic [N_CH-1:0]   ciclo_fim
);

    localparam int unsigned PS_W = $clog2(TICK_DIV);
    localparam int unsigned PC_W =
        $clog2(max_ticks(GREEN_TICKS, FLASH_TICKS, AMBER_TICKS) + 1);

    logic [PS_W-1:0] presc_q;
    logic            tick;

    assign tick = (presc_q == PS_W'(TICK_DIV - 1));

    // Free-running prescaler, independent of any channel enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PS_W'(1);
        end
    end

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_canal
        sinal_canal #(
            .GREEN_TICKS (GREEN_TICKS),
            .FLASH_HALF  (FLASH_HALF),
            .FLASH_TICKS (FLASH_TICKS),
`ifdef SINAL_AMBER_EN
            .AMBER_TICKS (AMBER_TICKS),
`endif
            .PC_W        (PC_W)
        ) u_canal (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .en        (en[i]),
            .modo      (modo[2*i +: 2]),
            .verde     (verde[i]),
            .vermelho  (vermelho[i]),
`ifdef SINAL_AMBER_EN
            .amarelo   (amarelo[i]),
`endif
            .ciclo_fim (ciclo_fim[i])
        );
    end

endmodule
